// File: rtl/prio_code_decoder.sv
// rtl/prio_code_decoder.sv - priority-code to one-hot decoder with 2-entry output queue
// Optional feature macro: PRIO_DECODE_THERM_EN (adds out_mask thermometer output)
module prio_code_decoder #(
    parameter int ERR_CNT_W = 8,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
`ifdef PRIO_DECODE_THERM_EN
    ,
    output logic [7:0]           out_mask
`endif
);

    // The queue is hand-built as two fixed slots; other depths are rejected at elaboration.
    if (DEPTH != 2) begin : g_bad_depth
        $error("prio_code_decoder: only DEPTH=2 is supported");
    end

`ifdef PRIO_DECODE_THERM_EN
    localparam int ENTRY_W = 17;
`else
    localparam int ENTRY_W = 9;
`endif

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ENTRY_W-1:0]   r_e0;
    logic [ENTRY_W-1:0]   r_e1;
    logic [ENTRY_W-1:0]   w_new_entry;
    logic [7:0]           w_dec_data;
    logic                 w_dec_err;
    logic [7:0]           w_dec_mask;
    logic                 w_push;
    logic                 w_pop;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Decode the incoming code into one-hot data, thermometer mask and illegal flag.
    always_comb begin
        w_dec_data = 8'h00;
        w_dec_mask = 8'h00;
        w_dec_err  = 1'b0;
        if (in_code[3]) begin
            w_dec_err = 1'b1;
        end else if (in_code[2:0] != 3'd0) begin
            w_dec_data = 8'h01 << (in_code[2:0] - 3'd1);
            w_dec_mask = (8'h01 << in_code[2:0]) - 8'h01;
        end
    end

`ifdef PRIO_DECODE_THERM_EN
    assign w_new_entry = {w_dec_mask, w_dec_err, w_dec_data};
`else
    assign w_new_entry = {w_dec_err, w_dec_data};
    logic w_mask_unused;
    assign w_mask_unused = ^w_dec_mask;
`endif

    // State register: occupancy of the output queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: occupancy moves by push minus pop.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_next_state = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_next_state = S_FULL;
                else if (!w_push && w_pop) w_next_state = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_next_state = S_ONE;
            default: w_next_state = S_EMPTY;
        endcase
    end

    // Output logic: handshake flags depend only on registered occupancy.
    always_comb begin
        in_ready  = (r_state != S_FULL);
        out_valid = (r_state != S_EMPTY);
    end

    // Queue storage: r_e0 is the head, r_e1 the entry behind it; vacated slots are zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0 <= '0;
            r_e1 <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) r_e0 <= w_new_entry;
                end
                S_ONE: begin
                    if (w_push && w_pop) r_e0 <= w_new_entry;
                    else if (w_push)     r_e1 <= w_new_entry;
                    else if (w_pop)      r_e0 <= '0;
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_e0 <= r_e1;
                        r_e1 <= '0;
                    end
                end
                default: begin
                    r_e0 <= '0;
                    r_e1 <= '0;
                end
            endcase
        end
    end

    // Illegal-code counter: clear wins over increment, increment saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_err_cnt <= '0;
        end else if (w_push && w_dec_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign out_data = out_valid ? r_e0[7:0] : 8'h00;
    assign out_err  = out_valid ? r_e0[8]   : 1'b0;
`ifdef PRIO_DECODE_THERM_EN
    assign out_mask = out_valid ? r_e0[16:9] : 8'h00;
`endif

endmodule

// File: tb/tb_prio_code_decoder.sv
// tb/tb_prio_code_decoder.sv - directed self-checking bench for prio_code_decoder
module tb_prio_code_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_cnt;
    logic       err_clr;
`ifdef PRIO_DECODE_THERM_EN
    logic [7:0] out_mask;
`endif

    int total = 0;
    int bad   = 0;

    prio_code_decoder #(.ERR_CNT_W(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
`ifdef PRIO_DECODE_THERM_EN
        ,
        .out_mask  (out_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = 4'd0; out_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_errcnt got=%h exp=00", err_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        logic [3:0] codes [4];
        logic [7:0] exp_d [4];
        codes = '{4'd0, 4'd1, 4'd3, 4'd7};
        exp_d = '{8'h00, 8'h01, 8'h04, 8'h40};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = codes[i];
            tick();
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL single_data[%0d] got=%h exp=%h", i, out_data, exp_d[i]); end
            total++; if (out_err !== 1'b0) begin bad++; $display("FAIL single_err[%0d] got=%b exp=0", i, out_err); end
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain[%0d] got=%b exp=0", i, out_valid); end
        end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL single_errcnt got=%h exp=00", err_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 4'd2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", in_ready); end
        tick();
        in_code = 4'd5;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        tick();
        in_code = 4'd6;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b exp=0", in_ready); end
        total++; if (out_data !== 8'h02) begin bad++; $display("FAIL bp_head_stable got=%h exp=02", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL bp_second got=%h exp=10", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h20) begin bad++; $display("FAIL bp_third got=%h exp=20", out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [11];
        logic [7:0] exp_d [10];
        codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4};
        exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h01, 8'h02, 8'h04};
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = codes[0];
        tick();
        for (int i = 0; i < 10; i++) begin
            in_code = codes[i+1];
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
            total++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                bad++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_d[i]);
            end
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_data !== 8'h08) begin bad++; $display("FAIL b2b_last got=%h exp=08", out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 4'd8;
        tick();
        in_code = 4'd15;
        total++; if (out_data !== 8'h00 || out_err !== 1'b1) begin bad++; $display("FAIL ill_8 got=%h/%b exp=00/1", out_data, out_err); end
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h00 || out_err !== 1'b1) begin bad++; $display("FAIL ill_15 got=%h/%b exp=00/1", out_data, out_err); end
        tick();
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL ill_err_idle got=%b exp=0", out_err); end
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL ill_cnt2 got=%h exp=02", err_cnt); end
        in_valid = 1'b1; in_code = 4'd9; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL ill_clr_prio got=%h exp=00", err_cnt); end
        tick();
        in_valid = 1'b1; in_code = 4'd10;
        for (int i = 0; i < 255; i++) tick();
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL ill_cnt255 got=%h exp=ff", err_cnt); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL ill_saturate got=%h exp=ff", err_cnt); end
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_code = 4'd12; out_ready = 1'b0;
        tick(); tick();
        in_code = 4'd13;
        tick();
        in_valid = 1'b0;
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL ill_full_no_count got=%h exp=ff", err_cnt); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL ill_clr got=%h exp=00", err_cnt); end
        out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 4'd11;
        tick();
        in_code = 4'd2;
        tick();
        in_code = 4'd3;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", in_ready); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL rmid_cnt1 got=%h exp=01", err_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", out_data); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rmid_errcnt got=%h exp=00", err_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 4'd4;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h08) begin bad++; $display("FAIL rmid_code4 got=%b/%h exp=1/08", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_drain got=%b exp=0", out_valid); end
    endtask

`ifdef PRIO_DECODE_THERM_EN
    task automatic test_therm();
        logic [3:0] codes [5];
        logic [7:0] exp_m [5];
        logic [7:0] exp_d [5];
        codes = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd12};
        exp_m = '{8'h00, 8'h01, 8'h0F, 8'h7F, 8'h00};
        exp_d = '{8'h00, 8'h01, 8'h08, 8'h40, 8'h00};
        out_ready = 1'b1;
        total++; if (out_mask !== 8'h00) begin bad++; $display("FAIL therm_idle got=%h exp=00", out_mask); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_code = codes[i];
            tick();
            in_valid = 1'b0;
            total++; if (out_mask !== exp_m[i] || out_data !== exp_d[i]) begin
                bad++; $display("FAIL therm[%0d] got=%h/%h exp=%h/%h", i, out_mask, out_data, exp_m[i], exp_d[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
`ifdef PRIO_DECODE_THERM_EN
        test_therm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
